// File: rtl/canon_code_pkg.sv
// Shared definitions for the canonical-Huffman next_code generator: default
// sizing, derived-width helpers and the sequencer state encoding.
package canon_code_pkg;

    localparam int unsigned DEF_MAX_LEN = 15;
    localparam int unsigned DEF_CNT_W   = 9;

    // Address width able to hold lengths 0..max_len.
    function automatic int unsigned calc_len_w(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

    // next_code entries need one bit more than the longest code.
    function automatic int unsigned calc_code_w(input int unsigned max_len);
        return max_len + 1;
    endfunction

    // True for lengths that own a table entry (1..max_len).
    function automatic logic len_ok(input int unsigned len, input int unsigned max_len);
        return (len != 0) && (len <= max_len);
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        CHECK,
        DONE
    } state_e;

endpackage

// File: rtl/canon_len_count_rf.sv
// Per-length code-count register file. Entry 0 does not exist; writes to it
// or beyond MAX_LEN are dropped and reads there return 0.
module canon_len_count_rf
    import canon_code_pkg::*;
#(
    parameter  int unsigned MAX_LEN = DEF_MAX_LEN,
    parameter  int unsigned CNT_W   = DEF_CNT_W,
    localparam int unsigned LEN_W   = calc_len_w(MAX_LEN)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             we,
    input  logic [LEN_W-1:0] waddr,
    input  logic [CNT_W-1:0] wdata,
    input  logic [LEN_W-1:0] raddr,
    output logic [CNT_W-1:0] rdata
);

    logic [CNT_W-1:0] cnt_q [1:MAX_LEN];

    // Clear wins over a same-cycle write.
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            for (int unsigned i = 1; i <= MAX_LEN; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (we && len_ok(32'(waddr), MAX_LEN)) begin
            cnt_q[waddr] <= wdata;
        end
    end

    // Combinational read for the sequencer.
    always_comb begin
        rdata = '0;
        if (len_ok(32'(raddr), MAX_LEN)) begin
            rdata = cnt_q[raddr];
        end
    end

endmodule

// File: rtl/canon_next_code_gen.sv
// Canonical-Huffman next_code generator. Walks lengths 1..MAX_LEN one per
// clock after start, then spends one CHECK cycle and one DONE cycle.
// Define NEXT_CODE_KRAFT_CHK_EN to build the over-subscription / incomplete
// detectors; without it both flags read 0 and latency is unchanged.
module canon_next_code_gen
    import canon_code_pkg::*;
#(
    parameter  int unsigned MAX_LEN = DEF_MAX_LEN,
    parameter  int unsigned CNT_W   = DEF_CNT_W,
    localparam int unsigned LEN_W   = calc_len_w(MAX_LEN),
    localparam int unsigned CODE_W  = calc_code_w(MAX_LEN)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cnt_clr,
    input  logic              cnt_we,
    input  logic [LEN_W-1:0]  cnt_addr,
    input  logic [CNT_W-1:0]  cnt_wdata,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              oversub,
    output logic              incomplete,
    input  logic [LEN_W-1:0]  rd_addr,
    output logic [CODE_W-1:0] rd_data
);

    localparam int unsigned ACC_W = CODE_W + 1;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_rd;
    logic [ACC_W-1:0]   cnt_ext;
    logic               idle;
    logic [CODE_W-1:0]  next_code_q [1:MAX_LEN];

    assign idle    = (state_q == IDLE);
    assign busy    = (state_q == CALC) || (state_q == CHECK);
    assign done    = (state_q == DONE);
    assign cnt_ext = ACC_W'(cnt_rd);

    // Count table is only writable while idle; the sequencer reads it by len.
    canon_len_count_rf #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) u_cnt_rf (
        .clock (clock),
        .reset (reset),
        .clr   (cnt_clr && idle),
        .we    (cnt_we && idle),
        .waddr (cnt_addr),
        .wdata (cnt_wdata),
        .raddr (len_q),
        .rdata (cnt_rd)
    );

    // State, length counter and accumulator registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            acc_q   <= acc_d;
        end
    end

    // Next-state logic; acc doubles after adding each length's count.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        acc_d   = acc_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                    len_d   = LEN_W'(1);
                    acc_d   = '0;
                end
            end
            CALC: begin
                acc_d = (acc_q + cnt_ext) << 1;
                if (len_q == LEN_W'(MAX_LEN)) begin
                    state_d = CHECK;
                end else begin
                    len_d = len_q + LEN_W'(1);
                end
            end
            CHECK:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // next_code[len] takes the accumulator value on entry to step len.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 1; i <= MAX_LEN; i++) begin
                next_code_q[i] <= '0;
            end
        end else if (state_q == CALC) begin
            next_code_q[len_q] <= acc_q[CODE_W-1:0];
        end
    end

    // Registered read port; address 0 has no entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data <= '0;
        end else if (len_ok(32'(rd_addr), MAX_LEN)) begin
            rd_data <= next_code_q[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

`ifdef NEXT_CODE_KRAFT_CHK_EN
    localparam logic [ACC_W-1:0] FULL_SUM = ACC_W'(1) << CODE_W;

    logic             oversub_q, incomplete_q;
    logic [ACC_W-1:0] step_sum, len_pow;

    // Codes used so far versus the 2^len slots available at this length.
    always_comb begin
        step_sum = acc_q + cnt_ext;
        len_pow  = ACC_W'(1) << len_q;
    end

    // Sticky over-subscription; incomplete only judged when not over-subscribed.
    always_ff @(posedge clock) begin
        if (reset) begin
            oversub_q    <= 1'b0;
            incomplete_q <= 1'b0;
        end else if (idle && start) begin
            oversub_q    <= 1'b0;
            incomplete_q <= 1'b0;
        end else if (state_q == CALC) begin
            if (step_sum > len_pow) begin
                oversub_q <= 1'b1;
            end
        end else if (state_q == CHECK) begin
            incomplete_q <= !oversub_q && (acc_q < FULL_SUM);
        end
    end

    assign oversub    = oversub_q;
    assign incomplete = incomplete_q;
`else
    assign oversub    = 1'b0;
    assign incomplete = 1'b0;
`endif

endmodule

// File: tb/tb_canon_next_code_gen.sv
// Scoreboard bench for canon_next_code_gen: stimulus pushes expected read data
// and done events into queues; negedge monitors pop and compare.
module tb_canon_next_code_gen;

    localparam int unsigned LEN_W  = 4;
    localparam int unsigned CNT_W  = 9;
    localparam int unsigned CODE_W = 16;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              cnt_clr = 1'b0;
    logic              cnt_we = 1'b0;
    logic [LEN_W-1:0]  cnt_addr = '0;
    logic [CNT_W-1:0]  cnt_wdata = '0;
    logic              start = 1'b0;
    logic              busy, done, oversub, incomplete;
    logic [LEN_W-1:0]  rd_addr = '0;
    logic [CODE_W-1:0] rd_data;

    typedef struct {int cyc; bit ov; bit inc;} done_exp_t;
    typedef struct {int addr; int val;} rd_exp_t;

    done_exp_t done_q[$];
    rd_exp_t   rd_q[$];

    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    logic rd_issue = 1'b0;
    logic rd_vld   = 1'b0;
    int   t0;

    canon_next_code_gen dut (
        .clock      (clock),
        .reset      (reset),
        .cnt_clr    (cnt_clr),
        .cnt_we     (cnt_we),
        .cnt_addr   (cnt_addr),
        .cnt_wdata  (cnt_wdata),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .oversub    (oversub),
        .incomplete (incomplete),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc    <= cyc + 1;
        rd_vld <= rd_issue;
    end

    function automatic void chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Flags only exist when the Kraft checker is built in.
    function automatic bit kr(input bit x);
`ifdef NEXT_CODE_KRAFT_CHK_EN
        return x;
`else
        return 1'b0 & x;
`endif
    endfunction

    // Monitors: read port and done pulse.
    always @(negedge clock) begin
        rd_exp_t   re;
        done_exp_t de;
        if (rd_vld) begin
            if (rd_q.size() == 0) begin
                n_chk++;
                $display("FAIL rd_unexpected: got read data %0d with nothing expected", rd_data);
            end else begin
                re = rd_q.pop_front();
                chk($sformatf("rd[%0d]", re.addr), int'(rd_data), re.val);
            end
        end
        if (done) begin
            if (done_q.size() == 0) begin
                n_chk++;
                $display("FAIL done_unexpected: got done=1 at cycle %0d expected none", cyc);
            end else begin
                de = done_q.pop_front();
                chk("done_cycle", cyc, de.cyc);
                chk("oversub", int'(oversub), int'(de.ov));
                chk("incomplete", int'(incomplete), int'(de.inc));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        cnt_addr  = LEN_W'(a);
        cnt_wdata = CNT_W'(d);
        cnt_we    = 1'b1;
        tick();
        cnt_we    = 1'b0;
    endtask

    task automatic clr();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
    endtask

    task automatic rd(input int a, input int v);
        rd_addr  = LEN_W'(a);
        rd_issue = 1'b1;
        rd_q.push_back('{a, v});
        tick();
        rd_issue = 1'b0;
    endtask

    task automatic drain();
        tick();
        if (rd_q.size() != 0) begin
            n_chk++;
            $display("FAIL rd_drain: got %0d reads outstanding expected 0", rd_q.size());
            rd_q.delete();
        end
    endtask

    // Start pulse with an expected done at T+17.
    task automatic go(input bit ov, input bit inc);
        done_q.push_back('{cyc + 17, kr(ov), kr(inc)});
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && done_q.size() != 0; i++) tick();
        if (done_q.size() != 0) begin
            n_chk++;
            $display("FAIL done_timeout: got no done expected one by cycle %0d", done_q[0].cyc);
            done_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected one before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clock);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_oversub", int'(oversub), 0);
        chk("rst_incomplete", int'(incomplete), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        tick();

        // Literal table 7:24, 8:152, 9:112.
        wr(7, 24); wr(8, 152); wr(9, 112);
        go(0, 0);
        wait_done();
        rd(7, 0); rd(8, 48); rd(9, 400); rd(10, 1024); rd(15, 32768); rd(1, 0); rd(0, 0);
        drain();

        // RFC 1951 example; the length-4 write shares the start cycle.
        clr(); wr(2, 1); wr(3, 5);
        cnt_addr = 4'd4; cnt_wdata = 9'd2; cnt_we = 1'b1;
        go(0, 0);
        cnt_we = 1'b0;
        wait_done();
        rd(1, 0); rd(2, 0); rd(3, 2); rd(4, 14);
        drain();

        // Over-subscribed: three length-1 codes.
        clr(); wr(1, 3);
        go(1, 0);
        wait_done();
        rd(2, 6); rd(15, 49152);
        drain();

        // Empty set.
        clr();
        go(0, 1);
        wait_done();
        for (int i = 0; i <= 15; i++) rd(i, 0);
        drain();

        // Single length-1 code.
        clr(); wr(1, 1);
        go(0, 1);
        wait_done();
        rd(2, 2); rd(15, 16384);
        drain();

        // Restart and count write during CALC are ignored.
        clr(); wr(2, 1); wr(3, 5); wr(4, 2);
        go(0, 0);
        repeat (4) tick();
        chk("busy_calc", int'(busy), 1);
        start = 1'b1; cnt_addr = 4'd3; cnt_wdata = 9'd100; cnt_we = 1'b1;
        tick();
        start = 1'b0; cnt_we = 1'b0;
        wait_done();
        rd(3, 2); rd(4, 14);
        drain();
        go(0, 0);
        wait_done();
        rd(4, 14); rd(5, 32);
        drain();

        // Reset at T+8 aborts; no done pulse follows.
        clr(); wr(7, 24); wr(8, 152); wr(9, 112);
        t0 = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (cyc < t0 + 8) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        repeat (25) tick();
        rd(8, 0); rd(10, 0);
        drain();
        go(0, 1);
        wait_done();
        rd(10, 0); rd(2, 0);
        drain();

        // Clear beats write; address-0 write dropped.
        cnt_clr = 1'b1; cnt_we = 1'b1; cnt_addr = 4'd1; cnt_wdata = 9'd3;
        tick();
        cnt_clr = 1'b0; cnt_we = 1'b0;
        wr(0, 5);
        go(0, 1);
        wait_done();
        rd(2, 0); rd(15, 0);
        drain();

        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
